shift_arbiter: RTL

Shares one 32-bit shift datapath (SLL/SRL/SRA, five-stage log shifter) between two requesters over valid/ready handshakes. Round-robin grant, one-cycle registered result, one result in flight at a time. It sits between the integer execute stage (port 0) and the load/store alignment helper (port 1). Only these two requesters drive the shifter.

---
 rtl/shift_arbiter_if.sv | 43 ++++
 rtl/shift_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter_if.sv
// Bundle of the two requester ports of the shared shifter.
// Each port has a request channel (valid/ready + op/a/b) and a response
// channel (valid/ready). The response data bus is shared by both ports and
// is qualified by whichever rsp_valid is asserted.
interface shift_arbiter_if #(
   parameter int XLEN = 32
);
   logic            p0_req_valid;
   logic            p0_req_ready;
   logic [1:0]      p0_req_op;
   logic [XLEN-1:0] p0_req_a;
   logic [XLEN-1:0] p0_req_b;
   logic            p0_rsp_valid;
   logic            p0_rsp_ready;

   logic            p1_req_valid;
   logic            p1_req_ready;
   logic [1:0]      p1_req_op;
   logic [XLEN-1:0] p1_req_a;
   logic [XLEN-1:0] p1_req_b;
   logic            p1_rsp_valid;
   logic            p1_rsp_ready;

   logic [XLEN-1:0] rsp_data;

   // Requester side (execute stage / load-store alignment helper).
   modport master (
      output p0_req_valid, p0_req_op, p0_req_a, p0_req_b, p0_rsp_ready,
      output p1_req_valid, p1_req_op, p1_req_a, p1_req_b, p1_rsp_ready,
      input  p0_req_ready, p0_rsp_valid,
      input  p1_req_ready, p1_rsp_valid,
      input  rsp_data
   );

   // Arbiter side.
   modport slave (
      input  p0_req_valid, p0_req_op, p0_req_a, p0_req_b, p0_rsp_ready,
      input  p1_req_valid, p1_req_op, p1_req_a, p1_req_b, p1_rsp_ready,
      output p0_req_ready, p0_rsp_valid,
      output p1_req_ready, p1_rsp_valid,
      output rsp_data
   );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit log shifter (SLL/SRL/SRA) between
// two requesters. One result is held at a time; a result that retires in the
// same cycle a new request is accepted is replaced immediately, giving one
// operation per cycle when consumers are always ready.
module shift_arbiter #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic           clk,
   input  logic           rst,
   shift_arbiter_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic            prio_r;
   logic            owner_r;
   logic [XLEN-1:0] rsp_data_r;

   logic            owner_ready_s;
   logic            free_s;
   logic            grant_s;
   logic            accept_s;
   logic [1:0]      sel_op_s;
   logic [XLEN-1:0] sel_a_s;
   logic [SHW-1:0]  sel_sh_s;
   logic [XLEN-1:0] shift_res_s;

   // Only the low SHW bits of the shift amount matter; the rest are dropped.
   logic            unused_b_s;
   assign unused_b_s = ^{bus.p0_req_b[XLEN-1:SHW], bus.p1_req_b[XLEN-1:SHW]};

   // Five-stage logarithmic shifter. Right shifts (01/11) pull in the fill
   // bit from the top; 00 and the reserved 10 both shift left with zeros.
   function automatic logic [XLEN-1:0] log_shift(
      input logic [1:0]      op,
      input logic [XLEN-1:0] a,
      input logic [SHW-1:0]  sh
   );
      logic [XLEN-1:0]   v;
      logic [2*XLEN-1:0] wide;
      logic              fill;
      v    = a;
      fill = (op == 2'b11) ? a[XLEN-1] : 1'b0;
      for (int s = 0; s < SHW; s++) begin
         if (sh[s]) begin
            case (op)
               2'b01, 2'b11: begin
                  wide = {{XLEN{fill}}, v} >> (32'd1 << s);
                  v    = wide[XLEN-1:0];
               end
               default: begin
                  v = v << (32'd1 << s);
               end
            endcase
         end else begin
            v = v;
         end
      end
      return v;
   endfunction

   // Arbitration: decide whether a new request can be taken and which port wins.
   always_comb begin
      owner_ready_s = 1'b0;
      free_s        = 1'b0;
      grant_s       = 1'b0;
      if (owner_r) begin
         owner_ready_s = bus.p1_rsp_ready;
      end else begin
         owner_ready_s = bus.p0_rsp_ready;
      end
      case (state_r)
         IDLE:    free_s = 1'b1;
         RESP:    free_s = owner_ready_s;
         default: free_s = 1'b0;
      endcase
      if (bus.p0_req_valid && bus.p1_req_valid) begin
         grant_s = prio_r;
      end else if (bus.p1_req_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
      accept_s = free_s & (bus.p0_req_valid | bus.p1_req_valid) & ~rst;
   end

   assign bus.p0_req_ready = accept_s & ~grant_s;
   assign bus.p1_req_ready = accept_s &  grant_s;

   // Operand steering from the granted port into the shifter.
   always_comb begin
      sel_op_s = 2'b00;
      sel_a_s  = {XLEN{1'b0}};
      sel_sh_s = {SHW{1'b0}};
      if (grant_s) begin
         sel_op_s = bus.p1_req_op;
         sel_a_s  = bus.p1_req_a;
         sel_sh_s = bus.p1_req_b[SHW-1:0];
      end else begin
         sel_op_s = bus.p0_req_op;
         sel_a_s  = bus.p0_req_a;
         sel_sh_s = bus.p0_req_b[SHW-1:0];
      end
      shift_res_s = log_shift(sel_op_s, sel_a_s, sel_sh_s);
   end

   // Next-state logic: a retire with no new accept drops back to IDLE,
   // a retire with an accept stays in RESP with the new result.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RESP: begin
            if (accept_s) begin
               state_nxt_s = RESP;
            end else if (owner_ready_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Result, owner and round-robin priority capture on each accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_r     <= 1'b0;
         owner_r    <= 1'b0;
         rsp_data_r <= {XLEN{1'b0}};
      end else if (accept_s) begin
         prio_r     <= ~grant_s;
         owner_r    <= grant_s;
         rsp_data_r <= shift_res_s;
      end else begin
         prio_r     <= prio_r;
         owner_r    <= owner_r;
         rsp_data_r <= rsp_data_r;
      end
   end

   assign bus.p0_rsp_valid = (state_r == RESP) & ~owner_r;
   assign bus.p1_rsp_valid = (state_r == RESP) &  owner_r;
   assign bus.rsp_data     = rsp_data_r;

endmodule
